// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main controller for a multicycle ARM-subset datapath. A ten-state Moore
//   FSM sequences fetch, decode, memory, execute and writeback. Instruction
//   decode supplies the ALU operation, extender and register-address selects.
//   A conditional-execution unit (Flags register, CondEx, CondExD) gates the
//   architectural write strobes.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   Instr       in   [19:0] instruction bits [31:12]: Cond[19:16] Op[15:14]
//                    Funct[13:8] Rd[3:0]
//   ALUFlags    in   [3:0] {N,Z,C,V} produced by the ALU this cycle
//   PCWrite     out  PC write strobe
//   IRWrite     out  instruction register write strobe
//   RegWrite    out  register file write strobe
//   MemWrite    out  data memory write strobe
//   AdrSrc      out  memory address: 0 = PC, 1 = ALU out register
//   ALUSrcA     out  0 = register A, 1 = PC
//   ALUSrcB     out  [1:0] 00 = register B, 01 = ExtImm, 10 = constant 4
//   ResultSrc   out  [1:0] 00 = ALU out reg, 01 = data reg, 10 = ALU result
//   ImmSrc      out  [1:0] extender select (equals Op)
//   RegSrc      out  [1:0] register-read-address selects
//   ALUControl  out  [1:0] 00 ADD, 01 SUB, 10 AND, 11 ORR
//   State       out  [3:0] current FSM state
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t state, state_next;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_bits;

  assign cond        = Instr[19:16];
  assign op          = Instr[15:14];
  assign funct       = Instr[13:8];
  assign rd          = Instr[3:0];
  assign unused_bits = ^Instr[7:4];

  // ARM condition codes evaluated against the stored {N,Z,C,V}.
  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_check = z;
      4'b0001: cond_check = ~z;
      4'b0010: cond_check = cy;
      4'b0011: cond_check = ~cy;
      4'b0100: cond_check = n;
      4'b0101: cond_check = ~n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = ~v;
      4'b1000: cond_check = cy & ~z;
      4'b1001: cond_check = ~cy | z;
      4'b1010: cond_check = ~(n ^ v);
      4'b1011: cond_check = n ^ v;
      4'b1100: cond_check = ~z & ~(n ^ v);
      4'b1101: cond_check = z | (n ^ v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  logic [3:0] flags;
  logic       cond_ex;
  logic       cond_ex_d;

  assign cond_ex = cond_check(cond, flags);

  // ALU command decode; an unrecognised command falls back to ADD and
  // suppresses any flag update.
  logic [1:0] alu_dec;
  logic       alu_known;
  logic       alu_arith;

  always_comb begin
    alu_dec   = 2'b00;
    alu_known = 1'b1;
    alu_arith = 1'b0;
    case (funct[4:1])
      4'b0100: alu_arith = 1'b1;
      4'b0010: begin
        alu_dec   = 2'b01;
        alu_arith = 1'b1;
      end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: alu_known = 1'b0;
    endcase
  end

  logic exec_state;
  assign exec_state = (state == EXECR) || (state == EXECI);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Flags and delayed condition. CondExD lets writeback use the condition
  // seen before the execute cycle's own flag update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags     <= 4'b0000;
      cond_ex_d <= 1'b0;
    end else begin
      cond_ex_d <= cond_ex;
      if (exec_state && funct[0] && cond_ex && alu_known) begin
        flags[3:2] <= ALUFlags[3:2];
        if (alu_arith) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  logic ir_w;
  logic reg_w;
  logic mem_w;
  logic branch;
  logic alu_op;

  // Next state and Moore outputs
  always_comb begin
    state_next = FETCH;
    ir_w       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    case (state)
      FETCH: begin
        state_next = DECODE;
        ir_w       = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   state_next = funct[5] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        state_next = funct[0] ? MEMRD : MEMWR;
        ALUSrcB    = 2'b01;
      end
      MEMRD: begin
        state_next = MEMWB;
        AdrSrc     = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECR: begin
        state_next = ALUWB;
        alu_op     = 1'b1;
      end
      EXECI: begin
        state_next = ALUWB;
        ALUSrcB    = 2'b01;
        alu_op     = 1'b1;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  assign ALUControl = alu_op ? alu_dec : 2'b00;
  assign ImmSrc     = op;
  assign RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
  assign State      = state;

  // Strobes are held low for the whole reset assertion, independent of state.
  assign IRWrite  = ~reset & ir_w;
  assign RegWrite = ~reset & reg_w & cond_ex_d;
  assign MemWrite = ~reset & mem_w & cond_ex_d;
  assign PCWrite  = ~reset & ((state == FETCH) |
                              (cond_ex_d & (branch | (reg_w & (rd == 4'hF)))));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Scoreboard bench for multicycle_ctrl. The driver walks whole
//   instructions, predicting each one's state path, its condition outcome and
//   its flag effect, and queues the expected outputs for every cycle. A
//   monitor on the falling edge pops one entry per cycle and compares.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  State;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .State      (State)
  );

  typedef struct packed {
    logic       pcw, irw, rw, mw, adrsrc, srca;
    logic [1:0] srcb, ressrc, immsrc, regsrc, aluctl;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    outs_t o;
    string tag;
  } rec_t;

  rec_t       sb[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [3:0] m_flags = 4'h0;

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] cmd);
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  // Expected outputs for one cycle: st is the state the instruction occupies,
  // ok is whether its condition passed, rst forces the reset view.
  function automatic outs_t expect_out(input int st, input logic [19:0] ins,
                                       input bit ok, input bit rst);
    outs_t      o;
    logic [1:0] op;
    logic [5:0] fn;
    bit         regw, memw, br, aluop;
    op = ins[15:14];
    fn = ins[13:8];
    regw = 0; memw = 0; br = 0; aluop = 0;
    o = '0;
    o.state  = 4'(st);
    o.immsrc = op;
    o.regsrc = {(op == 2'b01) && !fn[0], op == 2'b10};
    case (st)
      0: begin o.irw = 1; o.srca = 1; o.srcb = 2'b10; o.ressrc = 2'b10; end
      1: begin o.srca = 1; o.srcb = 2'b10; o.ressrc = 2'b10; end
      2: o.srcb = 2'b01;
      3: o.adrsrc = 1;
      4: begin o.ressrc = 2'b01; regw = 1; end
      5: begin o.adrsrc = 1; memw = 1; end
      6: aluop = 1;
      7: begin o.srcb = 2'b01; aluop = 1; end
      8: regw = 1;
      9: begin o.srcb = 2'b01; o.ressrc = 2'b10; br = 1; end
      default: ;
    endcase
    if (aluop) o.aluctl = alu_code(fn[4:1]);
    o.rw  = regw && ok;
    o.mw  = memw && ok;
    o.pcw = (st == 0) || (ok && (br || (regw && ins[3:0] == 4'hF)));
    if (rst) begin
      o.pcw = 0; o.irw = 0; o.rw = 0; o.mw = 0;
    end
    return o;
  endfunction

  // Caller is at posedge+1 with the DUT in FETCH.
  task automatic do_reset(input int cycles);
    rec_t r;
    reset = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      r.o = expect_out(0, Instr, 1'b0, 1'b1);
      r.tag = "reset";
      sb.push_back(r);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    m_flags = 4'h0;
  endtask

  // af_exec < 0 gives random ALUFlags in the execute cycle; abort_idx selects
  // the step of the path at which reset is asserted (-1 for none).
  task automatic run_instr(input logic [19:0] ins, input int af_exec,
                           input int abort_idx, input string tag);
    int         path[$];
    bit         ok;
    bit         known;
    bit         arith;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] af;
    rec_t       r;
    op    = ins[15:14];
    fn    = ins[13:8];
    ok    = cond_holds(ins[19:16], m_flags);
    known = (fn[4:1] == 4'b0100) || (fn[4:1] == 4'b0010) ||
            (fn[4:1] == 4'b0000) || (fn[4:1] == 4'b1100);
    arith = (fn[4:1] == 4'b0100) || (fn[4:1] == 4'b0010);
    path.push_back(0);
    path.push_back(1);
    case (op)
      2'b00: begin
        path.push_back(fn[5] ? 7 : 6);
        path.push_back(8);
      end
      2'b01: begin
        path.push_back(2);
        if (fn[0]) begin path.push_back(3); path.push_back(4); end
        else path.push_back(5);
      end
      2'b10: path.push_back(9);
      default: ;
    endcase
    foreach (path[i]) begin
      Instr = ins;
      if (af_exec >= 0 && (path[i] == 6 || path[i] == 7)) af = 4'(af_exec);
      else af = 4'($urandom_range(0, 15));
      ALUFlags = af;
      if (i == abort_idx) begin
        reset = 1'b1;
        r.o = expect_out(0, ins, 1'b0, 1'b1);
        r.tag = {tag, "_abort"};
        sb.push_back(r);
        @(posedge clk); #1;
        reset = 1'b0;
        m_flags = 4'h0;
        return;
      end
      r.o = expect_out(path[i], ins, ok, 1'b0);
      r.tag = tag;
      sb.push_back(r);
      @(posedge clk); #1;
      if ((path[i] == 6 || path[i] == 7) && fn[0] && ok && known) begin
        m_flags[3:2] = af[3:2];
        if (arith) m_flags[1:0] = af[1:0];
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    rec_t  r;
    outs_t got;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      got = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
             ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State};
      n_checks++;
      if (got === r.o) n_pass++;
      else $display("FAIL %s (state %0d): got %05h required %05h",
                    r.tag, r.o.state, got, r.o);
    end
  end

  initial begin
    logic [19:0] ins;
    int          ab;
    @(posedge clk); #1;
    do_reset(2);
    run_instr(20'hE2812, -1, -1, "ADD_imm");
    run_instr(20'hE5903, -1, -1, "LDR");
    run_instr(20'hE5801, -1, -1, "STR");
    run_instr(20'hE2511,  4, -1, "SUBS_zero");
    run_instr(20'h0A000, -1, -1, "BEQ_taken");
    run_instr(20'hE2511,  0, -1, "SUBS_nonzero");
    run_instr(20'h0A000, -1, -1, "BEQ_not_taken");
    run_instr(20'h02812, -1, -1, "ADDEQ_skipped");
    run_instr(20'hE281F, -1, -1, "ADD_to_pc");
    run_instr(20'hE5801, -1,  3, "STR");
    run_instr(20'hE2812, -1, -1, "ADD_after_abort");
    for (int k = 0; k < 250; k++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 2) == 0) ins[19:16] = 4'hE;
      if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
      ab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(ins, -1, ab, "random");
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
